// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: arms on stb, waits for a masked trigger, stores a
// DEPTH-sample window and replays it over valid/ready. Optional macro: LA_FORCE_TRIGGER_EN.
module la_capture_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stb,
  input  logic [DATA_WIDTH-1:0] probe,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [7:0]            missed
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_idx_reg;
  logic [AW-1:0]         rd_idx_reg;
  logic                  rd_done_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic                  out_last_reg;
  logic [7:0]            missed_reg;

  logic [DATA_WIDTH-1:0] bit_ok;
  logic                  trig_hit;
  logic                  force_trig;
  logic                  fire;
  logic                  stb_missed;
  logic                  wr_en;
  logic                  wr_last;
  logic                  hs;
  logic                  hs_last;
  logic                  rd_load;

  // A bit matches when it is masked out or equals the required value.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_trig_bit
      assign bit_ok[gi] = ~trig_mask[gi] | ~(probe[gi] ^ trig_value[gi]);
    end
  endgenerate

  assign trig_hit = &bit_ok;

`ifdef LA_FORCE_TRIGGER_EN
  assign force_trig = stb;
  assign stb_missed = stb & ((state_reg == CAPTURE) | (state_reg == READOUT));
`else
  assign force_trig = 1'b0;
  assign stb_missed = stb & (state_reg != IDLE);
`endif

  assign fire = trig_hit | force_trig;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (stb)     state_next = ARMED;
      ARMED:   if (fire)    state_next = CAPTURE;
      CAPTURE: if (wr_last) state_next = READOUT;
      READOUT: if (hs_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy    = (state_reg != IDLE);
    wr_en   = ((state_reg == ARMED) & fire) | (state_reg == CAPTURE);
    wr_last = (state_reg == CAPTURE) & (wr_idx_reg == LAST_IDX);
    hs      = out_valid_reg & out_ready;
    hs_last = hs & out_last_reg;
    // Refill the output register whenever it is empty or being drained this cycle.
    rd_load = (state_reg == READOUT) & ~rd_done_reg & (~out_valid_reg | out_ready);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx_reg] <= probe;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_reg <= '0;
    end else if (wr_en) begin
      wr_idx_reg <= wr_idx_reg + 1'b1;
    end
  end

  // Registered memory read doubles as the output stage, so the first sample
  // appears two cycles after the final write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx_reg    <= '0;
      rd_done_reg   <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      if (rd_load) begin
        out_data_reg  <= mem[rd_idx_reg];
        out_last_reg  <= (rd_idx_reg == LAST_IDX);
        out_valid_reg <= 1'b1;
        rd_idx_reg    <= rd_idx_reg + 1'b1;
        if (rd_idx_reg == LAST_IDX) begin
          rd_done_reg <= 1'b1;
        end
      end else if (hs) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
      if (hs_last) begin
        rd_done_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      missed_reg <= 8'd0;
    end else if (stb_missed && (missed_reg != 8'hFF)) begin
      missed_reg <= missed_reg + 8'd1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign missed    = missed_reg;

endmodule

// File: doc/la_capture_ctrl.md
LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8, which sets the probe and sample width in bits.
REQ-002 The block SHALL have the parameter DEPTH, default 64, which sets the capture window length in samples and SHALL be a power of two of at least 4.
REQ-003 The block SHALL have the following ports:
- clk, input, 1 bit: the single system clock.
- reset, input, 1 bit: asynchronous, active-low reset.
- stb, input, 1 bit: one-cycle periodic arm strobe from the reset/strobe generator.
- probe, input, DATA_WIDTH bits: signals under observation, sampled every clk.
- trig_mask, input, DATA_WIDTH bits: 1 marks a bit that participates in the trigger.
- trig_value, input, DATA_WIDTH bits: required value of the masked bits.
- out_valid, output, 1 bit: a readout sample is present.
- out_ready, input, 1 bit: the consumer accepts the sample.
- out_data, output, DATA_WIDTH bits: the readout sample.
- out_last, output, 1 bit: marks the final sample of the window.
- busy, output, 1 bit: high in every state except IDLE.
- missed, output, 8 bits: saturating count of ignored strobes.

Function
REQ-004 The block SHALL implement the FSM states IDLE, ARMED, CAPTURE and READOUT.
REQ-005 From IDLE, stb=1 SHALL cause a transition to ARMED on the next edge.
REQ-006 The trigger condition SHALL be ((probe ^ trig_value) & trig_mask) == 0.
REQ-007 The trigger condition SHALL be evaluated on every ARMED cycle, starting with the first cycle after entry.
REQ-008 With trig_mask=0, the block SHALL trigger on the first ARMED cycle.
REQ-009 On the trigger cycle, probe SHALL be written as sample 0 and the FSM SHALL move to CAPTURE.
REQ-010 In CAPTURE, samples 1..DEPTH-1 SHALL be written on consecutive cycles, giving exactly DEPTH samples with no gaps.
REQ-011 Sample storage SHALL be an internal DEPTH x DATA_WIDTH memory.
REQ-012 The write index SHALL be $clog2(DEPTH) bits wide and SHALL wrap to 0 after each window.
REQ-013 After sample DEPTH-1 is written, the FSM SHALL enter READOUT.
REQ-014 out_valid SHALL first assert exactly 2 cycles after the write of sample DEPTH-1, carrying sample 0.
REQ-015 A handshake SHALL occur on a cycle where out_valid=1 and out_ready=1.
REQ-016 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-017 Samples SHALL be delivered in write order, with no bubbles while out_ready stays high.
REQ-018 out_last SHALL be 1 only with sample DEPTH-1.
REQ-019 The handshake of the sample carrying out_last SHALL deassert out_valid on the next cycle and return the FSM to IDLE.
REQ-020 stb in ARMED, CAPTURE or READOUT SHALL NOT disturb the capture (except as REQ-026 allows) and SHALL increment missed.
REQ-021 missed SHALL saturate at 255 and clear only on reset.
REQ-022 stb on the same cycle the FSM returns to IDLE SHALL count as missed and SHALL NOT arm.
REQ-023 out_valid SHALL be 0 outside READOUT.

Reset
REQ-024 While reset=0, the block SHALL force the FSM to IDLE, the write/read indices to 0, out_valid=0, out_last=0, out_data=0, busy=0 and missed=0, asynchronously.
REQ-025 Reset asserted mid-capture or mid-readout SHALL discard the window, and no output SHALL be produced after reset release until a new stb arms. Memory contents need not be cleared.

Configuration
REQ-026 With macro LA_FORCE_TRIGGER_EN defined, stb while ARMED SHALL force a trigger on that cycle instead of counting as missed, with probe written as sample 0 and capture proceeding normally. Without the macro, such stb SHALL be ignored and counted per REQ-020.

Verification
REQ-027 The bench SHALL use DATA_WIDTH=8, DEPTH=16 and cover the following scenarios:
- Capture with constant ready: mask=0xFF, value=0xA5, probe counts 0x00 upward, stb at t0, out_ready=1 -> 16 samples 0xA5..0xB4 in order, out_last on 0xB4, busy low afterwards, missed=0.
- Immediate trigger: mask=0x00, stb -> sample 0 equals probe on the first ARMED cycle, and out_valid rises exactly 2 cycles after sample 15 is written.
- Backpressure: out_ready toggling 1,0,0,1 repeatedly -> out_data and out_last stable during stalls, all 16 samples delivered exactly once, in order.
- Strobe during a window: 3 stb pulses during CAPTURE/READOUT -> missed=3 and the data is unaffected; 300 pulses -> missed=255.
- Reset mid-window: reset low during CAPTURE sample 7 -> all outputs 0 at once; after release, no out_valid appears until stb plus trigger.
- Macro variants: never-matching trigger (mask=0xFF, value=0xFF, probe=0x00) with a second stb -> with LA_FORCE_TRIGGER_EN a full capture starting at that cycle and missed=0; without it the FSM stays ARMED and missed=1.
